// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends each as a UART frame, LSB first.
// Default build is 8N1; define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLOCKS_PER_BAUD = 868,
    parameter int unsigned DW              = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_empty,
    input  logic [DW-1:0] i_data,
    output logic          o_rd,
    output logic          o_uart_tx,
    output logic          o_busy
);

    localparam logic [23:0] BaudReload = 24'(CLOCKS_PER_BAUD);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    state_e        state_q;
    logic [23:0]   baud_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [DW-1:0] shift_q;
    logic          uart_tx_q;
    logic          busy_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic baud_last;
    logic ready;

    assign baud_last = (baud_cnt_q == 24'd1);

    // Accepting on the last stop cycle lets back-to-back frames run with no idle gap.
    assign ready = (state_q == StIdle) || ((state_q == StStop) && baud_last);

    assign o_rd      = !i_reset && !i_empty && ready;
    assign o_uart_tx = uart_tx_q;
    assign o_busy    = busy_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (o_rd) begin
            state_q    <= StStart;
            baud_cnt_q <= BaudReload;
            bit_cnt_q  <= '0;
            shift_q    <= i_data;
            uart_tx_q  <= 1'b0;
            busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^i_data;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    uart_tx_q <= 1'b1;
                    busy_q    <= 1'b0;
                end

                // shift_q[0] always holds the next data bit to be put on the line.
                StStart: begin
                    if (baud_last) begin
                        state_q    <= StData;
                        baud_cnt_q <= BaudReload;
                        uart_tx_q  <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 24'd1;
                    end
                end

                StData: begin
                    if (baud_last) begin
                        baud_cnt_q <= BaudReload;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= StParity;
                            uart_tx_q <= parity_q;
`else
                            state_q   <= StStop;
                            uart_tx_q <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            uart_tx_q <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 24'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (baud_last) begin
                        state_q    <= StStop;
                        baud_cnt_q <= BaudReload;
                        uart_tx_q  <= 1'b1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 24'd1;
                    end
                end
`endif

                // Reaching the end here means the FIFO was empty, so the line goes idle.
                StStop: begin
                    if (baud_last) begin
                        state_q    <= StIdle;
                        baud_cnt_q <= '0;
                        uart_tx_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 24'd1;
                    end
                end

                default: begin
                    state_q    <= StIdle;
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    uart_tx_q  <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLOCKS_PER_BAUD=4 with a queue standing in for the FIFO.
// Frame expectations follow UART_TX_PARITY_EN when it is defined.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       i_reset;
    logic       i_empty;
    logic [7:0] i_data;
    logic       o_rd;
    logic       o_uart_tx;
    logic       o_busy;

    logic [7:0] fifo[$];
    int n_checks;
    int n_pass;
    int rd_cnt;
    int rd_at;

    fifo_uart_tx #(
        .CLOCKS_PER_BAUD(CPB),
        .DW             (8)
    ) u_dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_empty  (i_empty),
        .i_data   (i_data),
        .o_rd     (o_rd),
        .o_uart_tx(o_uart_tx),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_fifo();
        i_empty = (fifo.size() == 0);
        i_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: pop if the DUT strobed o_rd in the cycle just ending, then settle.
    task automatic tick();
        logic rd;
        rd = o_rd;
        @(posedge clk);
        if (rd && fifo.size() != 0) void'(fifo.pop_front());
        #1;
        drive_fifo();
        #1;
    endtask

    // Called on the first cycle of a start bit; checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] b, input string tag,
                               output int rd_n, output int rd_pos);
        logic [10:0] bits;
        int          mism;
        logic        busy_ok;
`ifdef UART_TX_PARITY_EN
        bits = {1'b0, 1'b1, ^b, b, 1'b0};
`else
        bits = {2'b01, 1'b1, b, 1'b0};
`endif
        busy_ok = 1'b1;
        rd_n    = 0;
        rd_pos  = -1;
        for (int k = 0; k < NB; k++) begin
            mism = 0;
            for (int j = 0; j < CPB; j++) begin
                if (o_uart_tx !== bits[k]) mism++;
                if (o_busy !== 1'b1) busy_ok = 1'b0;
                if (o_rd === 1'b1) begin
                    rd_n++;
                    rd_pos = k * CPB + j;
                end
                tick();
            end
            check($sformatf("%s_bit%0d_bad_cycles", tag, k), mism, 0);
        end
        check({tag, "_busy_high"}, busy_ok, 1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        i_reset  = 1'b1;
        fifo.push_back(8'hA5);
        drive_fifo();
        #1;

        // Reset held with a non-empty FIFO.
        for (int i = 0; i < 3; i++) begin
            check("rst_rd", o_rd, 0);
            tick();
            check("rst_tx", o_uart_tx, 1);
            check("rst_busy", o_busy, 0);
        end
        i_reset = 1'b0;
        #1;
        check("rd_after_rst", o_rd, 1);
        tick();

        // Single byte 0xA5.
        check_frame(8'hA5, "a5", rd_cnt, rd_at);
        check("a5_rd_count", rd_cnt, 0);
        check("a5_idle_busy", o_busy, 0);
        check("a5_idle_tx", o_uart_tx, 1);

        // Empty FIFO for 100 cycles.
        begin
            int rds, bad_tx, bad_busy;
            rds = 0; bad_tx = 0; bad_busy = 0;
            for (int i = 0; i < 100; i++) begin
                if (o_rd !== 1'b0) rds++;
                if (o_uart_tx !== 1'b1) bad_tx++;
                if (o_busy !== 1'b0) bad_busy++;
                tick();
            end
            check("empty_rd", rds, 0);
            check("empty_tx", bad_tx, 0);
            check("empty_busy", bad_busy, 0);
        end

        // Back-to-back 0x00 then 0xFF.
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        drive_fifo();
        #1;
        check("b2b_rd_first", o_rd, 1);
        tick();
        check_frame(8'h00, "b2b0", rd_cnt, rd_at);
        check("b2b0_rd_count", rd_cnt, 1);
        check("b2b0_rd_pos", rd_at, NB * CPB - 1);
        check_frame(8'hFF, "b2b1", rd_cnt, rd_at);
        check("b2b1_rd_count", rd_cnt, 0);
        check("b2b1_idle_busy", o_busy, 0);

        // Reset during data bit 3 of 0x55; 0x3C must follow intact.
        fifo.push_back(8'h55);
        fifo.push_back(8'h3C);
        drive_fifo();
        #1;
        tick();
        for (int i = 0; i < CPB * 4 + 1; i++) tick();
        check("mid_tx_bit3", o_uart_tx, 0);
        i_reset = 1'b1;
        #1;
        check("mid_rst_rd", o_rd, 0);
        tick();
        check("mid_rst_tx", o_uart_tx, 1);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_fifo_left", fifo.size(), 1);
        i_reset = 1'b0;
        #1;
        check("mid_rd_after", o_rd, 1);
        tick();
        check_frame(8'h3C, "post_rst", rd_cnt, rd_at);
        check("post_rst_rd_count", rd_cnt, 0);

`ifdef UART_TX_PARITY_EN
        // 0x07 has odd weight (parity 1); 0x03 has even weight (parity 0).
        fifo.push_back(8'h07);
        fifo.push_back(8'h03);
        drive_fifo();
        #1;
        tick();
        check_frame(8'h07, "par07", rd_cnt, rd_at);
        check("par07_rd_pos", rd_at, 43);
        check_frame(8'h03, "par03", rd_cnt, rd_at);
        check("par03_idle_busy", o_busy, 0);
`endif

        for (int i = 0; i < 5; i++) tick();
        check("final_idle_tx", o_uart_tx, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
